// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the pulse sequencer.
// Holds the FSM state encoding, the fixed step-table depth and the default
// widths of the high/low length fields and of the repeat count.
package pulse_seq_defs;

  localparam int DEPTH      = 4;
  localparam int LEN_W_DFLT = 16;
  localparam int REP_W_DFLT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_sequencer_pulse.sv
// Free-running two-phase pulse generator.
// After a synchronous reset the output is low for length2+1 cycles, then high
// for length1+1 cycles, and repeats for as long as reset stays low.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous, active-high; restarts at the beginning of the low phase
//   length1 - high phase length minus one
//   length2 - low phase length minus one
//   pulse   - registered waveform output
module pulse #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] length1,
  input  logic [WIDTH-1:0] length2,
  output logic             pulse
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!r_phase) begin
      if (r_cnt == length2) begin
        r_phase <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      if (r_cnt == length1) begin
        r_phase <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pulse = r_phase;

endmodule

// File: rtl/pulse_sequencer.sv
// Table-driven pulse sequencer.
// A four-entry step table holds (high length, low length, repeat count) per
// step. On start the sequencer walks steps 0..num_steps, running each step's
// waveform for max(rep,1) periods, with one LOAD gap cycle between steps.
// The waveform itself comes from a single pulse generator instance.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start, stop         - launch from step 0 / abort to idle (stop wins)
//   loop_en             - wrap to step 0 after the last step instead of finishing
//   num_steps           - index of the last step used
//   cfg_we, cfg_addr,
//   cfg_high, cfg_low,
//   cfg_rep             - table write port, honoured only in IDLE or DONE
//   pulse_out           - sequenced waveform
//   busy                - high in LOAD or RUN
//   done                - one-cycle strobe on entering DONE
//   step                - active table index (0 in IDLE, held in DONE)
//   period_tick         - strobe per completed high/low period
module pulse_sequencer
  import pulse_seq_defs::*;
#(
  parameter int LEN_W = LEN_W_DFLT,
  parameter int REP_W = REP_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [1:0]       num_steps,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [LEN_W-1:0] cfg_high,
  input  logic [LEN_W-1:0] cfg_low,
  input  logic [REP_W-1:0] cfg_rep,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       step,
  output logic             period_tick
);

  // Index of the tick that completes a step; a repeat count of zero behaves as one.
  function automatic logic [REP_W-1:0] last_rep(input logic [REP_W-1:0] rep);
    return (rep == '0) ? '0 : rep - 1'b1;
  endfunction

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] r_rep;
  logic [LEN_W-1:0] r_high;
  logic [LEN_W-1:0] r_low;
  logic             r_pulse_q;
  logic             r_done;

  logic [LEN_W-1:0] r_tbl_high [DEPTH];
  logic [LEN_W-1:0] r_tbl_low  [DEPTH];
  logic [REP_W-1:0] r_tbl_rep  [DEPTH];

  logic             w_run;
  logic             w_idle_or_done;
  logic             w_pulse;
  logic             w_tick;
  logic             w_step_done;
  logic [1:0]       w_next_idx;

  assign w_run          = (r_state == ST_RUN);
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // Falling edge of the generator output marks the end of one full period.
  assign w_tick         = w_run & r_pulse_q & ~w_pulse;
  assign w_step_done    = w_tick && (r_rep_cnt == last_rep(r_rep));
  assign w_next_idx     = (r_idx < num_steps) ? r_idx + 2'd1 : 2'd0;

  // Generator is held in reset outside RUN, so every step starts on a fresh low phase.
  pulse #(
    .WIDTH (LEN_W + 1)
  ) u_pulse (
    .clk     (clk),
    .reset   (!w_run),
    .length1 ({1'b0, r_high}),
    .length2 ({1'b0, r_low}),
    .pulse   (w_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_rep_cnt <= '0;
      r_rep     <= '0;
      r_high    <= '0;
      r_low     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              r_state   <= ST_LOAD;
              r_idx     <= 2'd0;
              r_rep_cnt <= '0;
              r_high    <= r_tbl_high[0];
              r_low     <= r_tbl_low[0];
              r_rep     <= r_tbl_rep[0];
            end
          end
          ST_LOAD: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_step_done) begin
              r_rep_cnt <= '0;
              if ((r_idx < num_steps) || loop_en) begin
                r_state <= ST_LOAD;
                r_idx   <= w_next_idx;
                r_high  <= r_tbl_high[w_next_idx];
                r_low   <= r_tbl_low[w_next_idx];
                r_rep   <= r_tbl_rep[w_next_idx];
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end else if (w_tick) begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !w_run) begin
      r_pulse_q <= 1'b0;
    end else begin
      r_pulse_q <= w_pulse;
    end
  end

  // Writes are dropped while busy; a write on the start edge lands after the
  // load has already sampled the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_high[i] <= '0;
        r_tbl_low[i]  <= '0;
        r_tbl_rep[i]  <= '0;
      end
    end else if (cfg_we && w_idle_or_done) begin
      r_tbl_high[cfg_addr] <= cfg_high;
      r_tbl_low[cfg_addr]  <= cfg_low;
      r_tbl_rep[cfg_addr]  <= cfg_rep;
    end
  end

  assign pulse_out   = w_pulse & w_run;
  assign busy        = (r_state == ST_LOAD) || w_run;
  assign done        = r_done;
  assign step        = (r_state == ST_IDLE) ? 2'd0 : r_idx;
  assign period_tick = w_tick;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer: directed scenarios plus randomized runs,
// with expected tick/done events predicted by a timeline model and checked
// by an independent monitor.
module tb_pulse_sequencer;

  localparam int LEN_W = 16;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [1:0]       num_steps = 2'd0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_addr = 2'd0;
  logic [LEN_W-1:0] cfg_high = '0;
  logic [LEN_W-1:0] cfg_low = '0;
  logic [REP_W-1:0] cfg_rep = '0;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [1:0]       step;
  logic             period_tick;

  pulse_sequencer #(
    .LEN_W (LEN_W),
    .REP_W (REP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .num_steps   (num_steps),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_high    (cfg_high),
    .cfg_low     (cfg_low),
    .cfg_rep     (cfg_rep),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .step        (step),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit is_done;
    int step;
    int highs;
  } ev_t;

  ev_t exp_q[$];

  // Reference copy of the step table as the bench believes it to be.
  int m_high[4];
  int m_low[4];
  int m_rep[4];

  int hi_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every tick or done strobe must match the next predicted event,
  // including its cycle, its step and the number of high cycles since the
  // previous event.
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!reset) begin
      if (period_tick || done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got tick=%0b done=%0b step=%0d at cycle %0d, expected no event",
                   period_tick, done, step, cyc);
        end else begin
          e  = exp_q.pop_front();
          ok = (cyc == e.cyc) && (done == e.is_done) && (period_tick == !e.is_done) &&
               (int'(step) == e.step) && (hi_cnt == e.highs);
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL event: got cyc=%0d tick=%0b done=%0b step=%0d highs=%0d, expected cyc=%0d done=%0b step=%0d highs=%0d",
                     cyc, period_tick, done, step, hi_cnt, e.cyc, e.is_done, e.step, e.highs);
          end
        end
        hi_cnt = 0;
      end else if (!busy) begin
        hi_cnt = 0;
      end else if (pulse_out) begin
        hi_cnt++;
      end
    end
  end

  task automatic tick_wait();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: relative time 0 is the cycle after the start edge (LOAD).
  // Each step runs from the following cycle; a period lasts high+low+2 cycles
  // and its tick appears on the first cycle after it. Completion of the last
  // repeat is followed by a LOAD cycle (next step) or the DONE cycle.
  task automatic plan(input int base, input int nsteps, input bit lp, input int stop_t,
                      output int end_t);
    int t;
    int idx;
    int runstart;
    int per;
    int reps;
    int tt;
    bit fin;
    ev_t e;
    t     = 0;
    idx   = 0;
    fin   = 1'b0;
    end_t = stop_t;
    while (!fin) begin
      runstart = t + 1;
      reps     = (m_rep[idx] == 0) ? 1 : m_rep[idx];
      per      = m_high[idx] + m_low[idx] + 2;
      for (int k = 1; k <= reps; k++) begin
        tt = runstart + per * k;
        if (!fin && stop_t > 0 && tt >= stop_t) fin = 1'b1;
        if (!fin) begin
          e.cyc     = base + tt;
          e.is_done = 1'b0;
          e.step    = idx;
          e.highs   = m_high[idx] + 1;
          exp_q.push_back(e);
        end
      end
      if (!fin) begin
        t = runstart + per * reps + 1;
        if (idx < nsteps) begin
          idx++;
        end else if (lp) begin
          idx = 0;
        end else begin
          if (!(stop_t > 0 && t >= stop_t)) begin
            e.cyc     = base + t;
            e.is_done = 1'b1;
            e.step    = idx;
            e.highs   = 0;
            exp_q.push_back(e);
          end
          if (stop_t == 0) end_t = t;
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic cfg_write(input int a, input int h, input int l, input int r, input bit upd);
    cfg_we   = 1'b1;
    cfg_addr = a[1:0];
    cfg_high = h[LEN_W-1:0];
    cfg_low  = l[LEN_W-1:0];
    cfg_rep  = r[REP_W-1:0];
    tick_wait();
    cfg_we = 1'b0;
    if (upd) begin
      m_high[a] = h;
      m_low[a]  = l;
      m_rep[a]  = r;
    end
  endtask

  // Launch a sequence. stop_t>0 aborts with stop sampled at that relative edge.
  // same_wr writes the cfg arguments on the start edge; busy_wr attempts the
  // same write two cycles into the run (which must be dropped).
  task automatic launch(input int nsteps, input bit lp, input int stop_t,
                        input bit same_wr, input bit busy_wr,
                        input int ca, input int ch, input int cl, input int cr);
    int base;
    int end_t;
    num_steps = nsteps[1:0];
    loop_en   = lp;
    cfg_addr  = ca[1:0];
    cfg_high  = ch[LEN_W-1:0];
    cfg_low   = cl[LEN_W-1:0];
    cfg_rep   = cr[REP_W-1:0];
    cfg_we    = same_wr;
    start     = 1'b1;
    base      = cyc + 1;
    plan(base, nsteps, lp, stop_t, end_t);
    tick_wait();
    start  = 1'b0;
    cfg_we = 1'b0;
    if (same_wr) begin
      m_high[ca] = ch;
      m_low[ca]  = cl;
      m_rep[ca]  = cr;
    end
    if (stop_t > 0) begin
      while (cyc < base + stop_t - 1) tick_wait();
      stop = 1'b1;
      tick_wait();
      stop = 1'b0;
      check("busy_after_stop", busy, 0);
      check("step_after_stop", step, 0);
    end else begin
      while (cyc < base + end_t) begin
        cfg_we = busy_wr && (cyc == base + 2);
        tick_wait();
      end
      cfg_we = 1'b0;
    end
    repeat (2) tick_wait();
    check("idle_after_run", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse_out"}, pulse_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_period_tick"}, period_tick, 0);
    check({tag, "_step"}, step, 0);
  endtask

  initial begin
    int waited;
    int h;
    int l;
    int r;
    int ns;
    bit lp;
    int st;

    for (int i = 0; i < 4; i++) begin
      m_high[i] = 0;
      m_low[i]  = 0;
      m_rep[i]  = 0;
    end

    // Reset state
    repeat (3) tick_wait();
    check_all_zero("reset");
    reset = 1'b0;
    tick_wait();

    // Single step: high 2, low 3, rep 1 -> tick at +8, done at +9
    cfg_write(0, 2, 3, 1, 1'b1);
    launch(0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Repeat 3 with 4-cycle periods, then rep=0 behaving as one
    cfg_write(0, 1, 1, 3, 1'b1);
    launch(0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
    cfg_write(0, 1, 1, 0, 1'b1);
    launch(0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Two steps looping, aborted by stop
    cfg_write(0, 1, 1, 1, 1'b1);
    cfg_write(1, 3, 0, 2, 1'b1);
    launch(1, 1'b1, 60, 1'b0, 1'b0, 0, 0, 0, 0);

    // stop and start on the same edge stay idle
    start = 1'b1;
    stop  = 1'b1;
    tick_wait();
    start = 1'b0;
    stop  = 1'b0;
    check("stop_start_busy", busy, 0);
    check("stop_start_pulse", pulse_out, 0);
    tick_wait();
    check("stop_start_busy2", busy, 0);

    // Write while busy is dropped; a readback run still uses the old entry
    cfg_write(0, 2, 1, 2, 1'b1);
    launch(0, 1'b0, 0, 1'b0, 1'b1, 0, 0, 0, 0);
    launch(0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Write on the start edge: this run uses the old entry, the next the new one
    launch(0, 1'b0, 0, 1'b1, 1'b0, 0, 1, 0, 1);
    launch(0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Randomized runs
    for (int it = 0; it < 12; it++) begin
      for (int a = 0; a < 4; a++) begin
        h = $urandom_range(0, 4);
        l = $urandom_range(0, 4);
        r = $urandom_range(0, 3);
        cfg_write(a, h, l, r, 1'b1);
      end
      ns = $urandom_range(0, 3);
      lp = 1'($urandom_range(0, 1));
      if (lp) st = $urandom_range(20, 90);
      else if ($urandom_range(0, 3) == 0) st = $urandom_range(3, 40);
      else st = 0;
      launch(ns, lp, st, 1'b0, 1'b0, 0, 0, 0, 0);
    end

    // Reset during a high cycle, then a run from the cleared table
    cfg_write(0, 5, 1, 1, 1'b1);
    num_steps = 2'd0;
    loop_en   = 1'b0;
    start     = 1'b1;
    tick_wait();
    start  = 1'b0;
    waited = 0;
    while (!pulse_out && waited < 20) begin
      tick_wait();
      waited++;
    end
    check("reach_high_before_reset", pulse_out, 1);
    reset = 1'b1;
    exp_q.delete();
    tick_wait();
    reset = 1'b0;
    check_all_zero("mid_run_reset");
    for (int i = 0; i < 4; i++) begin
      m_high[i] = 0;
      m_low[i]  = 0;
      m_rep[i]  = 0;
    end
    tick_wait();
    launch(0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

    repeat (3) tick_wait();
    check("all_events_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
